// File: rtl/sar_search.sv
// Successive-approximation controller: drives trial values into an external
// magnitude comparator and converges on the unknown operand A.
module sar_search #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_cmp_gt,
    input  logic             i_cmp_eq,
    input  logic             i_cmp_lt,
    output logic [WIDTH-1:0] o_trial,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_found,
    output logic             o_err
);

    localparam int unsigned KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PROBE  = 2'd1,
        S_VERIFY = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [KW-1:0]    r_k;

    logic             w_onehot;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_bit_next;
    logic [WIDTH-1:0] w_msb;

    assign w_onehot   = ( i_cmp_gt & ~i_cmp_eq & ~i_cmp_lt) |
                        (~i_cmp_gt &  i_cmp_eq & ~i_cmp_lt) |
                        (~i_cmp_gt & ~i_cmp_eq &  i_cmp_lt);
    // A > trial means bit k of A is set, so the trial (with bit k) becomes acc
    assign w_acc_next = i_cmp_gt ? o_trial : r_acc;
    assign w_bit_next = WIDTH'(1) << (r_k - KW'(1));
    assign w_msb      = WIDTH'(1) << (WIDTH - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_k      <= '0;
            o_trial  <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_result <= '0;
            o_found  <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    o_trial <= '0;
                    o_busy  <= 1'b0;
                    if (i_start) begin
                        r_acc    <= '0;
                        r_k      <= KW'(WIDTH - 1);
                        o_trial  <= w_msb;
                        o_busy   <= 1'b1;
                        o_result <= '0;
                        o_found  <= 1'b0;
                        o_err    <= 1'b0;
                        r_state  <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    if (!w_onehot || i_cmp_eq) begin
                        o_result <= w_onehot ? o_trial : '0;
                        o_found  <= w_onehot;
                        o_err    <= ~w_onehot;
                        o_done   <= 1'b1;
                        o_busy   <= 1'b0;
                        o_trial  <= '0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        if (r_k != '0) begin
                            o_trial <= w_acc_next | w_bit_next;
                            r_k     <= r_k - KW'(1);
                        end else begin
                            o_trial <= w_acc_next;
                            r_state <= S_VERIFY;
                        end
                    end
                end
                S_VERIFY: begin
                    o_result <= w_onehot ? r_acc : '0;
                    o_found  <= w_onehot & i_cmp_eq;
                    o_err    <= ~w_onehot;
                    o_done   <= 1'b1;
                    o_busy   <= 1'b0;
                    o_trial  <= '0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    o_trial <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: behavioural comparator plus fault injection
// on the flags, with hand-computed trial sequences and results.
module tb_sar_search;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             i_start;
    logic             i_cmp_gt;
    logic             i_cmp_eq;
    logic             i_cmp_lt;
    logic [WIDTH-1:0] o_trial;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_result;
    logic             o_found;
    logic             o_err;

    logic [WIDTH-1:0] r_a;
    logic             ovr;
    logic             f_gt, f_eq, f_lt;

    int n_vec = 0;
    int n_err = 0;

    // Search knobs applied at a given cycle count after the start edge
    int               chg_cyc;
    logic [WIDTH-1:0] chg_a;
    int               frc_cyc;
    logic             frc_gt, frc_eq, frc_lt;
    int               stb_cyc;

    int               cyc;
    logic [31:0]      seq;

    sar_search #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_start),
        .i_cmp_gt (i_cmp_gt),
        .i_cmp_eq (i_cmp_eq),
        .i_cmp_lt (i_cmp_lt),
        .o_trial  (o_trial),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result),
        .o_found  (o_found),
        .o_err    (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign i_cmp_gt = ovr ? f_gt : (r_a >  o_trial);
    assign i_cmp_eq = ovr ? f_eq : (r_a == o_trial);
    assign i_cmp_lt = ovr ? f_lt : (r_a <  o_trial);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_knobs();
        chg_cyc = -1; chg_a = '0;
        frc_cyc = -1; frc_gt = 1'b0; frc_eq = 1'b0; frc_lt = 1'b0;
        stb_cyc = -1;
    endtask

    // Pulse start, log each trial nibble while busy, stop at done or budget
    task automatic search();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        cyc = 0;
        seq = '0;
        while (!o_done && cyc < 20) begin
            seq = {seq[27:0], o_trial};
            tick();
            cyc++;
            if (cyc == chg_cyc) r_a = chg_a;
            ovr = (cyc == frc_cyc);
            f_gt = frc_gt; f_eq = frc_eq; f_lt = frc_lt;
            i_start = (cyc == stb_cyc);
        end
        ovr = 1'b0;
        i_start = 1'b0;
    endtask

    task automatic check_search(input string tag, input int e_cyc, input logic [31:0] e_seq,
                                input logic [WIDTH-1:0] e_res, input logic e_found, input logic e_err);
        chk({tag, "_latency"}, 32'(cyc), 32'(e_cyc));
        chk({tag, "_trials"}, seq, e_seq);
        chk({tag, "_done"}, 32'(o_done), 32'd1);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_result"}, 32'(o_result), 32'(e_res));
        chk({tag, "_found"}, 32'(o_found), 32'(e_found));
        chk({tag, "_err"}, 32'(o_err), 32'(e_err));
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; r_a = '0; ovr = 1'b0;
        f_gt = 1'b0; f_eq = 1'b0; f_lt = 1'b0;
        clear_knobs();
        cyc = 0; seq = '0;
        tick(); tick();
        chk("rst_trial", 32'(o_trial), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_result", 32'(o_result), 32'd0);
        chk("rst_flags", {29'd0, o_found, o_err, o_done}, 32'd0);
        rst = 1'b0;
        tick();

        // A=11: 8 gt, 12 lt, 10 gt, 11 eq
        r_a = 4'd11;
        search();
        check_search("a11", 4, 32'h8CAB, 4'd11, 1'b1, 1'b0);
        tick();
        chk("a11_done_pulse", 32'(o_done), 32'd0);
        chk("a11_result_held", 32'(o_result), 32'd11);

        // A=0 walks every bit then verifies on 0
        r_a = 4'd0;
        search();
        check_search("a0", 5, 32'h84210, 4'd0, 1'b1, 1'b0);
        tick();

        // A=8 hits eq on the first probe
        r_a = 4'd8;
        search();
        check_search("a8", 1, 32'h8, 4'd8, 1'b1, 1'b0);
        tick();

        // A changes 11 -> 3 after E1
        r_a = 4'd11;
        chg_cyc = 1; chg_a = 4'd3;
        search();
        check_search("a_moved", 5, 32'h8CA98, 4'd8, 1'b0, 1'b0);
        clear_knobs();
        tick();

        // gt and lt together on the second probe
        r_a = 4'd11;
        frc_cyc = 1; frc_gt = 1'b1; frc_eq = 1'b0; frc_lt = 1'b1;
        search();
        check_search("bad_probe", 2, 32'h8C, 4'd0, 1'b0, 1'b1);
        clear_knobs();
        tick();

        // No flags at all in VERIFY with A=0
        r_a = 4'd0;
        frc_cyc = 4; frc_gt = 1'b0; frc_eq = 1'b0; frc_lt = 1'b0;
        search();
        check_search("bad_verify", 5, 32'h84210, 4'd0, 1'b0, 1'b1);
        clear_knobs();
        tick();

        // Reset mid-search after a completed search left result=11
        r_a = 4'd11;
        search();
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick(); tick();
        chk("pre_rst_busy", 32'(o_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_trial", 32'(o_trial), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_result", 32'(o_result), 32'd0);
        chk("mid_rst_flags", {29'd0, o_found, o_err, o_done}, 32'd0);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("post_rst_no_done", 32'(o_done), 32'd0);
        r_a = 4'd5;
        search();
        check_search("a5", 4, 32'h8465, 4'd5, 1'b1, 1'b0);
        tick();

        // start while busy must not disturb the running search
        r_a = 4'd11;
        stb_cyc = 2;
        search();
        check_search("start_busy", 4, 32'h8CAB, 4'd11, 1'b1, 1'b0);
        clear_knobs();
        tick();
        chk("start_busy_idle", 32'(o_busy), 32'd0);

        // start held high: relaunch in the done cycle
        r_a = 4'd8;
        i_start = 1'b1;
        tick();
        chk("hold_first_trial", 32'(o_trial), 32'd8);
        tick();
        chk("hold_done1", 32'(o_done), 32'd1);
        chk("hold_result1", 32'(o_result), 32'd8);
        tick();
        chk("hold_relaunch_trial", 32'(o_trial), 32'd8);
        chk("hold_relaunch_busy", 32'(o_busy), 32'd1);
        chk("hold_relaunch_clr", {29'd0, o_found, o_done, 1'b0}, 32'd0);
        i_start = 1'b0;
        tick();
        chk("hold_done2", 32'(o_done), 32'd1);
        chk("hold_result2", 32'(o_result), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
